// File: rtl/axil_csr_fifo_shell.sv
// AXI4-Lite slave shell: CSR bank plus PS->PL and PL->PS 32-bit FIFO channels.
// Word map: CSRs, then {data, free} per PS->PL channel, then {data, occupancy}
// per PL->PS channel; anything beyond that answers SLVERR.

module axil_csr_fifo_shell_fifo #(
    parameter int els_p = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enq,
    input  logic [31:0]             wdata,
    input  logic                    deq,
    output logic [31:0]             head,
    output logic [$clog2(els_p):0]  count,
    output logic                    full,
    output logic                    empty
);
    localparam int ptr_w = $clog2(els_p);
    localparam logic [ptr_w:0] els_c = (ptr_w + 1)'(els_p);

    logic [els_p-1:0][31:0] mem;
    logic [ptr_w-1:0]       wr_ptr, rd_ptr;

    // Storage has no reset; pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (enq) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap on their own because the depth is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + ptr_w'(1);
            if (deq) rd_ptr <= rd_ptr + ptr_w'(1);
            case ({enq, deq})
                2'b10:   count <= count + (ptr_w + 1)'(1);
                2'b01:   count <= count - (ptr_w + 1)'(1);
                default: ;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == els_c);
    assign empty = (count == '0);
endmodule

module axil_csr_fifo_shell #(
    parameter int addr_width_p = 10,
    parameter int num_regs_p   = 4,
    parameter int num_ps2pl_p  = 2,
    parameter int num_pl2ps_p  = 2,
    parameter int fifo_els_p   = 4
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [addr_width_p-1:0]       gp_axi_awaddr,
    input  logic [2:0]                    gp_axi_awprot,
    input  logic                          gp_axi_awvalid,
    output logic                          gp_axi_awready,
    input  logic [31:0]                   gp_axi_wdata,
    input  logic [3:0]                    gp_axi_wstrb,
    input  logic                          gp_axi_wvalid,
    output logic                          gp_axi_wready,
    output logic [1:0]                    gp_axi_bresp,
    output logic                          gp_axi_bvalid,
    input  logic                          gp_axi_bready,
    input  logic [addr_width_p-1:0]       gp_axi_araddr,
    input  logic [2:0]                    gp_axi_arprot,
    input  logic                          gp_axi_arvalid,
    output logic                          gp_axi_arready,
    output logic [31:0]                   gp_axi_rdata,
    output logic [1:0]                    gp_axi_rresp,
    output logic                          gp_axi_rvalid,
    input  logic                          gp_axi_rready,
    output logic [32*num_regs_p-1:0]      csr_data_o,
    output logic [32*num_ps2pl_p-1:0]     ps2pl_data_o,
    output logic [num_ps2pl_p-1:0]        ps2pl_v_o,
    input  logic [num_ps2pl_p-1:0]        ps2pl_yumi_i,
    input  logic [32*num_pl2ps_p-1:0]     pl2ps_data_i,
    input  logic [num_pl2ps_p-1:0]        pl2ps_v_i,
    output logic [num_pl2ps_p-1:0]        pl2ps_ready_o
);
    localparam int          cnt_w      = $clog2(fifo_els_p) + 1;
    localparam int unsigned base_ps2pl = num_regs_p;
    localparam int unsigned base_pl2ps = num_regs_p + 2 * num_ps2pl_p;
    localparam int unsigned num_words  = base_pl2ps + 2 * num_pl2ps_p;
    localparam logic [1:0]  resp_okay   = 2'b00;
    localparam logic [1:0]  resp_slverr = 2'b10;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_rsp_t;

    logic                                rst_done;
    logic [num_regs_p-1:0][31:0]         csr_q;
    logic                                aw_held, w_held;
    logic [addr_width_p-3:0]             aw_word_q;
    logic [31:0]                         w_data_q;
    logic [3:0]                          w_strb_q;
    logic                                aw_hs, w_hs, ar_hs, commit;
    logic [31:0]                         wr_idx, rd_idx, wr_data;
    logic [3:0]                          wr_strb;
    logic [1:0]                          wr_resp;
    rd_rsp_t                             rd_rsp;
    logic [num_ps2pl_p-1:0]              ps2pl_full, ps2pl_empty;
    logic [num_ps2pl_p-1:0][cnt_w-1:0]   ps2pl_cnt, ps2pl_free;
    logic [num_pl2ps_p-1:0]              pl2ps_full, pl2ps_empty;
    logic [num_pl2ps_p-1:0][cnt_w-1:0]   pl2ps_cnt;
    logic [num_pl2ps_p-1:0][31:0]        pl2ps_head;
    logic                                unused_ok;

    assign unused_ok = ^{gp_axi_awprot, gp_axi_arprot, gp_axi_awaddr[1:0], gp_axi_araddr[1:0]};

    assign gp_axi_awready = rst_done & ~aw_held & ~gp_axi_bvalid;
    assign gp_axi_wready  = rst_done & ~w_held & ~gp_axi_bvalid;
    assign gp_axi_arready = rst_done & ~gp_axi_rvalid;

    assign aw_hs  = gp_axi_awvalid & gp_axi_awready;
    assign w_hs   = gp_axi_wvalid & gp_axi_wready;
    assign ar_hs  = gp_axi_arvalid & gp_axi_arready;
    assign commit = (aw_held | aw_hs) & (w_held | w_hs);

    assign wr_idx  = 32'(aw_held ? aw_word_q : gp_axi_awaddr[addr_width_p-1:2]);
    assign wr_data = w_held ? w_data_q : gp_axi_wdata;
    assign wr_strb = w_held ? w_strb_q : gp_axi_wstrb;
    assign rd_idx  = 32'(gp_axi_araddr[addr_width_p-1:2]);

    assign csr_data_o = csr_q;

    // Ready outputs stay low until the first edge after reset release.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) rst_done <= 1'b0;
        else        rst_done <= 1'b1;
    end

    // Write response: unmapped words and writes into a full PS->PL FIFO fail.
    always_comb begin
        wr_resp = resp_okay;
        if (wr_idx >= num_words) wr_resp = resp_slverr;
        for (int c = 0; c < num_ps2pl_p; c++)
            if (wr_idx == base_ps2pl + 2 * c && ps2pl_full[c]) wr_resp = resp_slverr;
    end

    // AW/W holding registers and B channel; commit clears both holds.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            aw_word_q     <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            gp_axi_bvalid <= 1'b0;
            gp_axi_bresp  <= resp_okay;
        end else if (commit) begin
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            gp_axi_bvalid <= 1'b1;
            gp_axi_bresp  <= wr_resp;
        end else begin
            if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_word_q <= gp_axi_awaddr[addr_width_p-1:2];
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= gp_axi_wdata;
                w_strb_q <= gp_axi_wstrb;
            end
            if (gp_axi_bvalid && gp_axi_bready) gp_axi_bvalid <= 1'b0;
        end
    end

    // Byte-masked CSR update on commit.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            csr_q <= '0;
        end else if (commit) begin
            for (int i = 0; i < num_regs_p; i++)
                if (wr_idx == i)
                    for (int b = 0; b < 4; b++)
                        if (wr_strb[b]) csr_q[i][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

    // Read data mux; an empty PL->PS data word reads 0 with SLVERR.
    always_comb begin
        rd_rsp = '0;
        if (rd_idx >= num_words) rd_rsp.resp = resp_slverr;
        for (int i = 0; i < num_regs_p; i++)
            if (rd_idx == i) rd_rsp.data = csr_q[i];
        for (int c = 0; c < num_ps2pl_p; c++)
            if (rd_idx == base_ps2pl + 2 * c + 1) rd_rsp.data = 32'(ps2pl_free[c]);
        for (int c = 0; c < num_pl2ps_p; c++) begin
            if (rd_idx == base_pl2ps + 2 * c) begin
                if (pl2ps_empty[c]) rd_rsp.resp = resp_slverr;
                else                rd_rsp.data = pl2ps_head[c];
            end
            if (rd_idx == base_pl2ps + 2 * c + 1) rd_rsp.data = 32'(pl2ps_cnt[c]);
        end
    end

    // R channel: one outstanding read, response registered at AR handshake.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            gp_axi_rvalid <= 1'b0;
            gp_axi_rdata  <= '0;
            gp_axi_rresp  <= resp_okay;
        end else if (ar_hs) begin
            gp_axi_rvalid <= 1'b1;
            gp_axi_rdata  <= rd_rsp.data;
            gp_axi_rresp  <= rd_rsp.resp;
        end else if (gp_axi_rvalid && gp_axi_rready) begin
            gp_axi_rvalid <= 1'b0;
        end
    end

    for (genvar c = 0; c < num_ps2pl_p; c++) begin : g_ps2pl
        logic enq;
        assign enq = commit & (wr_idx == base_ps2pl + 2 * c) & ~ps2pl_full[c];
        axil_csr_fifo_shell_fifo #(.els_p(fifo_els_p)) u_fifo (
            .clk   (aclk),
            .rst   (areset),
            .enq   (enq),
            .wdata (wr_data),
            .deq   (ps2pl_yumi_i[c] & ~ps2pl_empty[c]),
            .head  (ps2pl_data_o[32*c +: 32]),
            .count (ps2pl_cnt[c]),
            .full  (ps2pl_full[c]),
            .empty (ps2pl_empty[c])
        );
        assign ps2pl_v_o[c]  = ~ps2pl_empty[c];
        assign ps2pl_free[c] = cnt_w'(fifo_els_p) - ps2pl_cnt[c];
    end

    for (genvar c = 0; c < num_pl2ps_p; c++) begin : g_pl2ps
        logic enq, deq;
        assign enq = pl2ps_v_i[c] & pl2ps_ready_o[c];
        assign deq = ar_hs & (rd_idx == base_pl2ps + 2 * c) & ~pl2ps_empty[c];
        axil_csr_fifo_shell_fifo #(.els_p(fifo_els_p)) u_fifo (
            .clk   (aclk),
            .rst   (areset),
            .enq   (enq),
            .wdata (pl2ps_data_i[32*c +: 32]),
            .deq   (deq),
            .head  (pl2ps_head[c]),
            .count (pl2ps_cnt[c]),
            .full  (pl2ps_full[c]),
            .empty (pl2ps_empty[c])
        );
        assign pl2ps_ready_o[c] = rst_done & ~pl2ps_full[c];
    end
endmodule

// File: tb/tb_axil_csr_fifo_shell.sv
// Directed bench for axil_csr_fifo_shell at default parameters.
module tb_axil_csr_fifo_shell;
    logic         aclk = 1'b0;
    logic         areset = 1'b1;
    logic [9:0]   awaddr = '0, araddr = '0;
    logic [2:0]   awprot = '0, arprot = '0;
    logic         awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic         awready, wready, bvalid, arready, rvalid;
    logic [31:0]  wdata = '0, rdata;
    logic [3:0]   wstrb = '0;
    logic [1:0]   bresp, rresp;
    logic [127:0] csr_data;
    logic [63:0]  ps2pl_data;
    logic [1:0]   ps2pl_v, ps2pl_yumi = '0;
    logic [63:0]  pl2ps_data = '0;
    logic [1:0]   pl2ps_v = '0, pl2ps_ready;

    int n_checks = 0, n_pass = 0;
    logic [31:0] rd_d;
    logic [1:0]  rsp;

    always #5 aclk = ~aclk;

    axil_csr_fifo_shell dut (
        .aclk(aclk), .areset(areset),
        .gp_axi_awaddr(awaddr), .gp_axi_awprot(awprot), .gp_axi_awvalid(awvalid), .gp_axi_awready(awready),
        .gp_axi_wdata(wdata), .gp_axi_wstrb(wstrb), .gp_axi_wvalid(wvalid), .gp_axi_wready(wready),
        .gp_axi_bresp(bresp), .gp_axi_bvalid(bvalid), .gp_axi_bready(bready),
        .gp_axi_araddr(araddr), .gp_axi_arprot(arprot), .gp_axi_arvalid(arvalid), .gp_axi_arready(arready),
        .gp_axi_rdata(rdata), .gp_axi_rresp(rresp), .gp_axi_rvalid(rvalid), .gp_axi_rready(rready),
        .csr_data_o(csr_data), .ps2pl_data_o(ps2pl_data), .ps2pl_v_o(ps2pl_v), .ps2pl_yumi_i(ps2pl_yumi),
        .pl2ps_data_i(pl2ps_data), .pl2ps_v_i(pl2ps_v), .pl2ps_ready_o(pl2ps_ready)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; returns the same way.
    task automatic axi_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
        for (int t = 0; t < 20 && !(awready && wready); t++) step();
        step();
        awvalid = 0; wvalid = 0;
        for (int t = 0; t < 20 && !bvalid; t++) step();
        check("wr_bvalid", bvalid, 1'b1);
        resp = bresp;
        step();
        bready = 0;
    endtask

    task automatic axi_read(input logic [9:0] a, output logic [31:0] d, output logic [1:0] resp);
        araddr = a; arvalid = 1; rready = 1;
        for (int t = 0; t < 20 && !arready; t++) step();
        step();
        arvalid = 0;
        for (int t = 0; t < 20 && !rvalid; t++) step();
        check("rd_rvalid", rvalid, 1'b1);
        d = rdata; resp = rresp;
        step();
        rready = 0;
    endtask

    initial begin
        // Reset state
        step(); step();
        check("rst_readies", {awready, wready, arready, pl2ps_ready}, 5'b0);
        check("rst_valids", {bvalid, rvalid, ps2pl_v}, 4'b0);
        check("rst_csr", csr_data, 128'h0);
        check("rst_rdata", {rdata, bresp, rresp}, 36'h0);
        areset = 0;
        check("rel_awready_lo", awready, 1'b0);
        step();
        check("rel_readies_hi", {awready, wready, arready, pl2ps_ready}, 5'b11111);

        // Byte-masked CSR write and readback
        axi_write(10'h04, 32'hDEADBEEF, 4'b0011, rsp);
        check("csr1_bresp", rsp, 2'b00);
        axi_read(10'h04, rd_d, rsp);
        check("csr1_rdata", rd_d, 32'h0000BEEF);
        check("csr1_rresp", rsp, 2'b00);
        check("csr1_out", csr_data[63:32], 32'h0000BEEF);
        check("csr0_out", csr_data[31:0], 32'h0);

        // W one cycle ahead of AW, then B back-pressure
        wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1; bready = 0;
        check("wfirst_wready", wready, 1'b1);
        step();
        wvalid = 0;
        check("wheld_wready", {wready, awready, bvalid}, 3'b010);
        awaddr = 10'h08; awvalid = 1;
        step();
        awvalid = 0;
        check("waw_bvalid", {bvalid, bresp}, 3'b100);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold", {bvalid, awready, wready}, 3'b100);
        end
        bready = 1;
        step();
        check("bp_release", bvalid, 1'b0);
        bready = 0;
        check("csr2_out", csr_data[95:64], 32'h12345678);

        // PS->PL channel 0: fill, overflow, pop
        for (int i = 1; i <= 5; i++) begin
            axi_write(10'h10, 32'(i), 4'hF, rsp);
            check("ps2pl_wr_resp", rsp, (i == 5) ? 2'b10 : 2'b00);
        end
        check("ps2pl_v", ps2pl_v, 2'b01);
        axi_read(10'h14, rd_d, rsp);
        check("ps2pl0_free_full", {rd_d, rsp}, {32'd0, 2'b00});
        axi_read(10'h1C, rd_d, rsp);
        check("ps2pl1_free_empty", rd_d, 32'd4);
        axi_read(10'h10, rd_d, rsp);
        check("ps2pl_data_rd", {rd_d, rsp}, {32'd0, 2'b00});
        for (int i = 1; i <= 4; i++) begin
            check("ps2pl_pop", {ps2pl_v[0], ps2pl_data[31:0]}, {1'b1, 32'(i)});
            ps2pl_yumi[0] = 1;
            step();
            ps2pl_yumi[0] = 0;
        end
        check("ps2pl_drained", ps2pl_v, 2'b00);
        axi_read(10'h14, rd_d, rsp);
        check("ps2pl0_free_after", rd_d, 32'd4);

        // PL->PS channel 1: two entries, drain, underflow
        pl2ps_data[63:32] = 32'hA5; pl2ps_v[1] = 1;
        step();
        pl2ps_data[63:32] = 32'h5A;
        step();
        pl2ps_v[1] = 0;
        axi_read(10'h2C, rd_d, rsp);
        check("pl2ps1_count", {rd_d, rsp}, {32'd2, 2'b00});
        axi_read(10'h28, rd_d, rsp);
        check("pl2ps1_pop0", {rd_d, rsp}, {32'hA5, 2'b00});
        axi_read(10'h28, rd_d, rsp);
        check("pl2ps1_pop1", {rd_d, rsp}, {32'h5A, 2'b00});
        axi_read(10'h28, rd_d, rsp);
        check("pl2ps1_empty", {rd_d, rsp}, {32'd0, 2'b10});
        axi_read(10'h2C, rd_d, rsp);
        check("pl2ps1_count0", rd_d, 32'd0);

        // PL->PS channel 0: fill to full, ready drops, extra beat refused
        pl2ps_v[0] = 1;
        for (int i = 0; i < 5; i++) begin
            pl2ps_data[31:0] = 32'h10 + 32'(i);
            step();
        end
        pl2ps_v[0] = 0;
        check("pl2ps0_ready_full", pl2ps_ready, 2'b10);
        axi_read(10'h24, rd_d, rsp);
        check("pl2ps0_count", rd_d, 32'd4);
        axi_read(10'h20, rd_d, rsp);
        check("pl2ps0_head", {rd_d, rsp}, {32'h10, 2'b00});
        check("pl2ps0_ready_back", pl2ps_ready, 2'b11);

        // Unmapped word
        axi_read(10'h30, rd_d, rsp);
        check("unmapped_rd", {rd_d, rsp}, {32'd0, 2'b10});
        axi_write(10'h30, 32'hFFFFFFFF, 4'hF, rsp);
        check("unmapped_wr", rsp, 2'b10);
        check("unmapped_csr", csr_data, 128'h00000000_12345678_0000BEEF_00000000);
        check("unmapped_fifo", ps2pl_v, 2'b00);

        // Reset with a pending write response and a non-empty FIFO
        axi_write(10'h18, 32'd7, 4'hF, rsp);
        check("ps2pl1_enq", {ps2pl_v, ps2pl_data[63:32]}, {2'b10, 32'd7});
        awaddr = 10'h0C; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
        step();
        awvalid = 0; wvalid = 0;
        check("pre_rst_bvalid", bvalid, 1'b1);
        check("pre_rst_csr3", csr_data[127:96], 32'hCAFEF00D);
        areset = 1;
        #1;
        check("mid_rst_bvalid", bvalid, 1'b0);
        check("mid_rst_outs", {awready, wready, arready, pl2ps_ready, ps2pl_v, rvalid}, 8'b0);
        check("mid_rst_csr", csr_data, 128'h0);
        step();
        areset = 0;
        step();
        check("post_rst_bvalid", bvalid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            axi_read(10'(4 * i), rd_d, rsp);
            check("post_rst_csr_rd", {rd_d, rsp}, 34'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
